// File: rtl/magic_pkg.sv
// Shared types and helpers for the streaming magic-square checker.
// Width helpers keep every instance consistent for any legal N.
package magic_pkg;

  typedef enum logic [1:0] {
    LOAD,
    EVAL,
    RESULT
  } state_t;

  function automatic int magic_target(input int n);
    return n * (n * n + 1) / 2;
  endfunction

  function automatic int num_width(input int n);
    return $clog2(n * n + 1);
  endfunction

  function automatic int sum_width(input int n);
    return $clog2(n * n * n * n + 1);
  endfunction

endpackage

// File: rtl/magic_sum_bank.sv
// Row, column and diagonal accumulators for one N x N grid.
// Flags when every line sum equals the magic target.
module magic_sum_bank
  import magic_pkg::*;
#(
  parameter int N     = 3,
  parameter int NUM_W = num_width(N),
  parameter int SUM_W = sum_width(N),
  parameter int IW    = $clog2(N)
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             add,
  input  logic [IW-1:0]    row,
  input  logic [IW-1:0]    col,
  input  logic [NUM_W-1:0] num,
  output logic             all_equal_target
);

  localparam logic [SUM_W-1:0] TARGET =
    SUM_W'(magic_target(N));

  logic [SUM_W-1:0] row_sum [N];
  logic [SUM_W-1:0] col_sum [N];
  logic [SUM_W-1:0] diag;
  logic [SUM_W-1:0] anti;
  logic [SUM_W-1:0] addend;
  logic             on_diag;
  logic             on_anti;

  assign addend  = SUM_W'(num);
  assign on_diag = (row == col);
  assign on_anti = (int'(row) + int'(col)) == (N - 1);

  // accumulate each accepted entry into its row, column and diagonals
  always_ff @(posedge clock) begin
    if (clear) begin
      for (int i = 0; i < N; i++) begin
        row_sum[i] <= '0;
        col_sum[i] <= '0;
      end
      diag <= '0;
      anti <= '0;
    end else if (add) begin
      row_sum[row] <= row_sum[row] + addend;
      col_sum[col] <= col_sum[col] + addend;
      if (on_diag) diag <= diag + addend;
      if (on_anti) anti <= anti + addend;
    end
  end

  // every line must hit the target for the grid to qualify
  always_comb begin
    all_equal_target = (diag == TARGET) && (anti == TARGET);
    for (int i = 0; i < N; i++) begin
      if (row_sum[i] != TARGET || col_sum[i] != TARGET)
        all_equal_target = 1'b0;
    end
  end

endmodule

// File: rtl/magic_square_stream_checker.sv
// Streams an N x N grid in row-major order and reports whether it
// is a magic square, holding the result until the consumer takes it.
module magic_square_stream_checker
  import magic_pkg::*;
#(
  parameter int N     = 3,
  parameter int NUM_W = $clog2(N*N+1),
  parameter int SUM_W = $clog2(N*N*N*N+1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NUM_W-1:0] in_num,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             it_is_magic,
  output logic [SUM_W-1:0] magic_constant
);

  localparam int NN   = N * N;
  localparam int IDXW = $clog2(NN);
  localparam int IW   = $clog2(N);
  localparam logic [SUM_W-1:0] TARGET =
    SUM_W'(magic_target(N));

  state_t          state;
  state_t          state_next;
  logic [IDXW-1:0] idx;
  logic [NN:0]     seen;
  logic            bad;
  logic            accept;
  logic            last;
  logic            clear;
  logic            in_range;
  logic            dup;
  logic            all_eq;
  logic            magic;
  logic [IW-1:0]   row;
  logic [IW-1:0]   col;

  assign accept   = in_valid && in_ready && !abort;
  assign last     = (idx == IDXW'(NN - 1));
  assign row      = IW'(idx / IDXW'(N));
  assign col      = IW'(idx % IDXW'(N));
  assign in_range = (in_num != '0) &&
                    (in_num <= NUM_W'(NN));
  assign dup      = in_range && seen[in_num];
  assign clear    = reset || abort ||
                    (state == RESULT && out_ready);
  assign magic    = !bad && all_eq;

  // state register
  always_ff @(posedge clock) begin
    if (reset) state <= LOAD;
    else       state <= state_next;
  end

  // next state and handshake outputs
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    unique case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (accept && last) state_next = EVAL;
      end
      EVAL: state_next = RESULT;
      RESULT: begin
        out_valid = 1'b1;
        if (out_ready) state_next = LOAD;
      end
      default: state_next = LOAD;
    endcase
    if (abort) state_next = LOAD;
  end

  // entry index, uniqueness bitmap and sticky bad flag
  always_ff @(posedge clock) begin
    if (clear) begin
      idx  <= '0;
      seen <= '0;
      bad  <= 1'b0;
    end else if (accept) begin
      idx <= last ? '0 : idx + 1'b1;
      bad <= bad | !in_range | dup;
      if (in_range) seen[in_num] <= 1'b1;
    end
  end

  // result registers, captured in EVAL and held through RESULT
  always_ff @(posedge clock) begin
    if (clear) begin
      it_is_magic    <= 1'b0;
      magic_constant <= '0;
    end else if (state == EVAL) begin
      it_is_magic    <= magic;
      magic_constant <= magic ? TARGET : '0;
    end
  end

  magic_sum_bank #(
    .N     (N),
    .NUM_W (NUM_W),
    .SUM_W (SUM_W),
    .IW    (IW)
  ) u_bank (
    .clock            (clock),
    .clear            (clear),
    .add              (accept),
    .row              (row),
    .col              (col),
    .num              (in_num),
    .all_equal_target (all_eq)
  );

endmodule
